// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and default widths for the unified RAM arbiter
package arm_mem_pkg;
  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  typedef enum logic {FAVOR_D, FAVOR_I} favor_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: fetch, data and RAM signals shared by the arbiter and its neighbours
interface ram_port_arbiter_if #(
  parameter int ADDR_W = arm_mem_pkg::MEM_ADDR_W,
  parameter int DATA_W = arm_mem_pkg::MEM_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_w_en;
  logic [DATA_W-1:0] ram_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ram_addr, ram_wdata, ram_w_en
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ram_addr, ram_wdata, ram_w_en
  );
endinterface

// File: rtl/mem_tag_pipe.sv
// mem_tag_pipe: DEPTH-stage owner tag shift register tracking reads through the RAM latency
module mem_tag_pipe
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t tag_i,
  output owner_t tag_o
);
  owner_t stage_q [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= OWN_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  assign tag_o = stage_q[DEPTH-1];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port RAM between fetch and data requesters,
// routing each read return back to its issuer after RD_LAT cycles.
module ram_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int MAX_STARVE = 3
) (
  input logic              clk,
  input logic              rst,
  ram_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  favor_t favor_q, favor_d;
  logic [SW-1:0] starve_q, starve_d;
  logic win_if, win_d;
  owner_t tag_in, tag_out;
  assign win_d  = !rst && bus.d_req && (favor_q == FAVOR_D || !bus.if_req);
  assign win_if = !rst && bus.if_req && !win_d;
  // Favor flips to IF in the same cycle the starve count reaches its limit
  always_comb begin
    starve_d = (!bus.if_req || win_if) ? '0 :
               (starve_q == SW'(MAX_STARVE)) ? starve_q : starve_q + 1'b1;
    favor_d  = favor_q;
    if (favor_q == FAVOR_D && starve_d == SW'(MAX_STARVE)) favor_d = FAVOR_I;
    else if (favor_q == FAVOR_I && win_if) favor_d = FAVOR_D;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      favor_q  <= FAVOR_D;
      starve_q <= '0;
    end else begin
      favor_q  <= favor_d;
      starve_q <= starve_d;
    end
  assign tag_in = win_if ? OWN_IF : (win_d && !bus.d_we) ? OWN_D : OWN_NONE;
  mem_tag_pipe #(.DEPTH(RD_LAT)) u_tags (
    .clk  (clk),
    .rst  (rst),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );
  assign bus.if_gnt    = win_if;
  assign bus.d_gnt     = win_d;
  assign bus.ram_addr  = win_if ? bus.if_addr : win_d ? bus.d_addr : '0;
  assign bus.ram_wdata = rst ? '0 : bus.d_wdata;
  assign bus.ram_w_en  = win_d && bus.d_we;
  assign bus.if_rvalid = tag_out == OWN_IF;
  assign bus.d_rvalid  = tag_out == OWN_D;
  assign bus.if_rdata  = bus.if_rvalid ? bus.ram_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of arbitration, read return and reset for RD_LAT=2 and RD_LAT=1
module tb_ram_port_arbiter;
  logic clk = 0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  ram_port_arbiter_if bus ();
  ram_port_arbiter_if bus1 ();
  ram_port_arbiter #(.RD_LAT(2), .MAX_STARVE(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  ram_port_arbiter #(.RD_LAT(1), .MAX_STARVE(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  assign bus1.if_req  = bus.if_req;
  assign bus1.if_addr = bus.if_addr;
  assign bus1.d_req   = bus.d_req;
  assign bus1.d_we    = bus.d_we;
  assign bus1.d_addr  = bus.d_addr;
  assign bus1.d_wdata = bus.d_wdata;
  function automatic logic [31:0] word(input logic [7:0] a);
    return a == 8'h10 ? 32'hE3A01005 : {24'hC0DE00, a};
  endfunction
  // write-first registered RAM models, one per latency
  logic [31:0] mem0 [256], mem1 [256], pipe0 [2], pipe1 [1];
  logic wr0 [256], wr1 [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        wr0[i] <= 1'b0;
        wr1[i] <= 1'b0;
      end
    end else begin
      if (bus.ram_w_en) begin
        mem0[bus.ram_addr] <= bus.ram_wdata;
        wr0[bus.ram_addr]  <= 1'b1;
      end
      if (bus1.ram_w_en) begin
        mem1[bus1.ram_addr] <= bus1.ram_wdata;
        wr1[bus1.ram_addr]  <= 1'b1;
      end
    end
    pipe0[0] <= bus.ram_w_en ? bus.ram_wdata : wr0[bus.ram_addr] ? mem0[bus.ram_addr] : word(bus.ram_addr);
    pipe0[1] <= pipe0[0];
    pipe1[0] <= bus1.ram_w_en ? bus1.ram_wdata : wr1[bus1.ram_addr] ? mem1[bus1.ram_addr] : word(bus1.ram_addr);
  end
  assign bus.ram_rdata  = pipe0[1];
  assign bus1.ram_rdata = pipe1[0];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic drv(input logic ir, input logic [7:0] ia, input logic dr, input logic we,
                     input logic [7:0] da, input logic [31:0] wd);
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = we;
    bus.d_addr  = da;
    bus.d_wdata = wd;
  endtask
  initial begin
    rst = 1;
    drv(1, 8'h04, 0, 0, 8'h00, 32'h12345678);
    repeat (2) @(posedge clk);
    mid;
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_w_en", bus.ram_w_en, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst1_if_gnt", bus1.if_gnt, 0);
    // reset mid-read
    nxt;
    rst = 0;
    mid;
    chk("rm_gnt", bus.if_gnt, 1);
    chk("rm_addr", bus.ram_addr, 32'h04);
    nxt;
    rst = 1;
    drv(0, 8'h00, 0, 0, 8'h00, 32'h0);
    mid;
    chk("rm_rst_gnt", bus.if_gnt, 0);
    chk("rm_rst_rvalid1", bus1.if_rvalid, 0);
    chk("rm_rst_rdata1", bus1.if_rdata, 0);
    nxt;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      mid;
      chk("rm_no_rvalid", bus.if_rvalid, 0);
      chk("rm_no_rvalid1", bus1.if_rvalid, 0);
      nxt;
    end
    // IF-only read, both latencies
    drv(1, 8'h10, 0, 0, 8'h00, 32'h0);
    mid;
    chk("ifo_gnt", bus.if_gnt, 1);
    chk("ifo_dgnt", bus.d_gnt, 0);
    chk("ifo_addr", bus.ram_addr, 32'h10);
    nxt;
    drv(0, 8'h00, 0, 0, 8'h00, 32'h0);
    mid;
    chk("ifo_c1_rvalid", bus.if_rvalid, 0);
    chk("lat1_rvalid", bus1.if_rvalid, 1);
    chk("lat1_rdata", bus1.if_rdata, 32'hE3A01005);
    nxt;
    mid;
    chk("ifo_rvalid", bus.if_rvalid, 1);
    chk("ifo_rdata", bus.if_rdata, 32'hE3A01005);
    chk("ifo_drvalid", bus.d_rvalid, 0);
    chk("ifo_drdata", bus.d_rdata, 0);
    chk("lat1_c2_rvalid", bus1.if_rvalid, 0);
    nxt;
    // contention: D wins three cycles, then IF is forced ahead
    drv(1, 8'h50, 1, 0, 8'h20, 32'h0);
    mid;
    chk("ct0_dgnt", bus.d_gnt, 1);
    chk("ct0_ifgnt", bus.if_gnt, 0);
    chk("ct0_addr", bus.ram_addr, 32'h20);
    nxt;
    drv(1, 8'h50, 1, 0, 8'h21, 32'h0);
    mid;
    chk("ct1_dgnt", bus.d_gnt, 1);
    chk("ct1_ifgnt", bus.if_gnt, 0);
    nxt;
    drv(1, 8'h50, 1, 0, 8'h22, 32'h0);
    mid;
    chk("ct2_dgnt", bus.d_gnt, 1);
    chk("ct2_drvalid", bus.d_rvalid, 1);
    chk("ct2_drdata", bus.d_rdata, 32'hC0DE0020);
    nxt;
    drv(1, 8'h50, 1, 0, 8'h23, 32'h0);
    mid;
    chk("ct3_ifgnt", bus.if_gnt, 1);
    chk("ct3_dgnt", bus.d_gnt, 0);
    chk("ct3_addr", bus.ram_addr, 32'h50);
    chk("ct3_drdata", bus.d_rdata, 32'hC0DE0021);
    nxt;
    drv(1, 8'h51, 1, 0, 8'h23, 32'h0);
    mid;
    chk("ct4_dgnt", bus.d_gnt, 1);
    chk("ct4_ifgnt", bus.if_gnt, 0);
    chk("ct4_drdata", bus.d_rdata, 32'hC0DE0022);
    chk("ct4_ifrvalid", bus.if_rvalid, 0);
    nxt;
    drv(0, 8'h00, 0, 0, 8'h00, 32'h0);
    mid;
    chk("ct5_ifrvalid", bus.if_rvalid, 1);
    chk("ct5_ifrdata", bus.if_rdata, 32'hC0DE0050);
    chk("ct5_drvalid", bus.d_rvalid, 0);
    nxt;
    mid;
    chk("ct6_drdata", bus.d_rdata, 32'hC0DE0023);
    nxt;
    // store then load to the same address
    drv(0, 8'h00, 1, 1, 8'h30, 32'hDEADBEEF);
    mid;
    chk("sl0_w_en", bus.ram_w_en, 1);
    chk("sl0_wdata", bus.ram_wdata, 32'hDEADBEEF);
    chk("sl0_dgnt", bus.d_gnt, 1);
    nxt;
    drv(0, 8'h00, 1, 0, 8'h30, 32'h0);
    mid;
    chk("sl1_w_en", bus.ram_w_en, 0);
    chk("sl1_dgnt", bus.d_gnt, 1);
    nxt;
    drv(0, 8'h00, 0, 0, 8'h00, 32'h0);
    mid;
    chk("sl2_drvalid", bus.d_rvalid, 0);
    chk("sl2_ifrvalid", bus.if_rvalid, 0);
    nxt;
    mid;
    chk("sl3_drvalid", bus.d_rvalid, 1);
    chk("sl3_drdata", bus.d_rdata, 32'hDEADBEEF);
    nxt;
    // back-to-back interleave IF, D, IF
    drv(1, 8'h00, 0, 0, 8'h00, 32'h0);
    nxt;
    drv(0, 8'h00, 1, 0, 8'h40, 32'h0);
    mid;
    chk("bb1_dgnt", bus.d_gnt, 1);
    nxt;
    drv(1, 8'h01, 0, 0, 8'h00, 32'h0);
    mid;
    chk("bb2_ifgnt", bus.if_gnt, 1);
    chk("bb2_ifrdata", bus.if_rdata, 32'hC0DE0000);
    chk("bb2_ifrvalid", bus.if_rvalid, 1);
    chk("bb2_drvalid", bus.d_rvalid, 0);
    nxt;
    drv(0, 8'h00, 0, 0, 8'h00, 32'h0);
    mid;
    chk("bb3_drvalid", bus.d_rvalid, 1);
    chk("bb3_drdata", bus.d_rdata, 32'hC0DE0040);
    chk("bb3_ifrvalid", bus.if_rvalid, 0);
    nxt;
    mid;
    chk("bb4_ifrvalid", bus.if_rvalid, 1);
    chk("bb4_ifrdata", bus.if_rdata, 32'hC0DE0001);
    chk("bb4_drvalid", bus.d_rvalid, 0);
    nxt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
